// File: rtl/reorder_buffer_pkg.sv
// Shared entry and retire-slot types for the reorder buffer.
// Tags are 6 bits wide, so up to 64 rows can be addressed.
package RSTableROBStruct;
    localparam int ROB_TAG_W    = 6;
    localparam int ROB_FU_COUNT = 3;

    typedef struct packed {
        logic                 used;
        logic                 completed;
        logic [ROB_TAG_W-1:0] p_rd;
        logic [ROB_TAG_W-1:0] p_old_rd;
        logic                 sw;
        logic [31:0]          data;
    } rob_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] p_rd;
        logic [31:0]          data;
        logic                 sw;
        logic                 free_valid;
        logic [ROB_TAG_W-1:0] free_preg;
    } rob_ret_t;

    function automatic rob_entry_t rob_alloc_entry(
        input logic [ROB_TAG_W-1:0] p_rd,
        input logic [ROB_TAG_W-1:0] p_old_rd,
        input logic                 sw
    );
        rob_entry_t e;
        e.used      = 1'b1;
        e.completed = 1'b0;
        e.p_rd      = p_rd;
        e.p_old_rd  = p_old_rd;
        e.sw        = sw;
        e.data      = '0;
        return e;
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retire bundle of the reorder buffer.
// master = pipeline side, slave = reorder buffer.
interface reorder_buffer_if
    import RSTableROBStruct::*;
#(
    parameter int FU_COUNT = ROB_FU_COUNT
);
    logic                 alloc1_valid;
    logic                 alloc2_valid;
    logic [ROB_TAG_W-1:0] alloc1_p_rd;
    logic [ROB_TAG_W-1:0] alloc1_p_old_rd;
    logic [ROB_TAG_W-1:0] alloc2_p_rd;
    logic [ROB_TAG_W-1:0] alloc2_p_old_rd;
    logic                 alloc1_sw;
    logic                 alloc2_sw;
    logic                 alloc_ready;
    logic [ROB_TAG_W-1:0] alloc1_tag;
    logic [ROB_TAG_W-1:0] alloc2_tag;

    logic                 cmpl_valid [FU_COUNT];
    logic [ROB_TAG_W-1:0] cmpl_tag   [FU_COUNT];
    logic [31:0]          cmpl_data  [FU_COUNT];

    logic                 ret_valid      [2];
    logic [ROB_TAG_W-1:0] ret_p_rd       [2];
    logic [31:0]          ret_data       [2];
    logic                 ret_sw         [2];
    logic                 ret_free_valid [2];
    logic [ROB_TAG_W-1:0] ret_free_preg  [2];
    logic                 rob_empty;

    modport master (
        output alloc1_valid, alloc2_valid, alloc1_p_rd, alloc1_p_old_rd,
        output alloc2_p_rd, alloc2_p_old_rd, alloc1_sw, alloc2_sw,
        output cmpl_valid, cmpl_tag, cmpl_data,
        input  alloc_ready, alloc1_tag, alloc2_tag,
        input  ret_valid, ret_p_rd, ret_data, ret_sw,
        input  ret_free_valid, ret_free_preg, rob_empty
    );

    modport slave (
        input  alloc1_valid, alloc2_valid, alloc1_p_rd, alloc1_p_old_rd,
        input  alloc2_p_rd, alloc2_p_old_rd, alloc1_sw, alloc2_sw,
        input  cmpl_valid, cmpl_tag, cmpl_data,
        output alloc_ready, alloc1_tag, alloc2_tag,
        output ret_valid, ret_p_rd, ret_data, ret_sw,
        output ret_free_valid, ret_free_preg, rob_empty
    );
endinterface

// File: rtl/rob_retire_picker.sv
// Head-window retire eligibility: how many entries leave this edge.
// ROB_RETIRE2_EN enables the second retire slot.
module rob_retire_picker (
    input  logic       head_used,
    input  logic       head_done,
    input  logic       next_used,
    input  logic       next_done,
    output logic [1:0] retire_cnt
);
`ifndef ROB_RETIRE2_EN
    logic unused_next;
    assign unused_next = next_used & next_done;
`endif

    always_comb begin
        retire_cnt = 2'd0;
        if (head_used && head_done) begin
`ifdef ROB_RETIRE2_EN
            retire_cnt = (next_used && next_done) ? 2'd2 : 2'd1;
`else
            retire_cnt = 2'd1;
`endif
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retire reorder buffer with dual dispatch and N writeback ports.
// Define ROB_RETIRE2_EN for two retirements per edge.
module reorder_buffer
    import RSTableROBStruct::*;
#(
    parameter int ROB_ROW_COUNT = 64,
    parameter int FU_COUNT      = ROB_FU_COUNT
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(ROB_ROW_COUNT);
    localparam int CNT_W = IDX_W + 1;
    typedef logic [IDX_W-1:0] idx_t;

    rob_entry_t       entries_q [ROB_ROW_COUNT];
    rob_entry_t       entries_d [ROB_ROW_COUNT];
    idx_t             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    rob_ret_t         ret_q [2];
    rob_ret_t         ret_d [2];

    idx_t       head1, tail1, slot, cidx;
    logic       alloc_ready, acc1, acc2;
    logic [1:0] n_alloc, retire_cnt;

    assign head1       = head_q + idx_t'(1);
    assign tail1       = tail_q + idx_t'(1);
    assign alloc_ready = count_q <= CNT_W'(ROB_ROW_COUNT - 2);
    assign acc1        = alloc_ready & bus.alloc1_valid;
    assign acc2        = acc1 & bus.alloc2_valid;
    assign n_alloc     = {1'b0, acc1} + {1'b0, acc2};

    rob_retire_picker u_picker (
        .head_used  (entries_q[head_q].used),
        .head_done  (entries_q[head_q].completed),
        .next_used  (entries_q[head1].used),
        .next_done  (entries_q[head1].completed),
        .retire_cnt (retire_cnt)
    );

    always_comb begin
        entries_d = entries_q;
        ret_d[0]  = '0;
        ret_d[1]  = '0;
        slot      = head_q;
        cidx      = '0;
        // Highest port first so the lowest index overwrites last and wins.
        for (int i = FU_COUNT - 1; i >= 0; i--) begin
            cidx = idx_t'(bus.cmpl_tag[i]);
            if (bus.cmpl_valid[i] && entries_q[cidx].used) begin
                entries_d[cidx].completed = 1'b1;
                entries_d[cidx].data      = bus.cmpl_data[i];
            end
        end
        if (acc1) begin
            entries_d[tail_q] = rob_alloc_entry(bus.alloc1_p_rd,
                bus.alloc1_p_old_rd, bus.alloc1_sw);
        end
        if (acc2) begin
            entries_d[tail1] = rob_alloc_entry(bus.alloc2_p_rd,
                bus.alloc2_p_old_rd, bus.alloc2_sw);
        end
        for (int s = 0; s < 2; s++) begin
            slot = head_q + idx_t'(s);
            if (retire_cnt > 2'(s)) begin
                ret_d[s].valid      = 1'b1;
                ret_d[s].p_rd       = entries_q[slot].p_rd;
                ret_d[s].data       = entries_q[slot].data;
                ret_d[s].sw         = entries_q[slot].sw;
                ret_d[s].free_valid = !entries_q[slot].sw &&
                                      (entries_q[slot].p_old_rd != '0);
                ret_d[s].free_preg  = entries_q[slot].p_old_rd;
                entries_d[slot].used = 1'b0;
            end
        end
        head_d  = head_q + idx_t'(retire_cnt);
        tail_d  = tail_q + idx_t'(n_alloc);
        count_d = count_q + CNT_W'(n_alloc) - CNT_W'(retire_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_ROW_COUNT; i++) begin
                entries_q[i].used      <= 1'b0;
                entries_q[i].completed <= 1'b0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ret_q[0] <= '0;
            ret_q[1] <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ret_q[0]  <= ret_d[0];
            ret_q[1]  <= ret_d[1];
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc1_tag  = ROB_TAG_W'(tail_q);
    assign bus.alloc2_tag  = ROB_TAG_W'(tail1);
    assign bus.rob_empty   = (count_q == '0);

    for (genvar s = 0; s < 2; s++) begin : g_ret
        assign bus.ret_valid[s]      = ret_q[s].valid;
        assign bus.ret_p_rd[s]       = ret_q[s].p_rd;
        assign bus.ret_data[s]       = ret_q[s].data;
        assign bus.ret_sw[s]         = ret_q[s].sw;
        assign bus.ret_free_valid[s] = ret_q[s].free_valid;
        assign bus.ret_free_preg[s]  = ret_q[s].free_preg;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner
// sequences and randomized traffic against an in-order queue model.
module tb_reorder_buffer;
    import RSTableROBStruct::*;

    localparam int N = 64;
    localparam int F = 3;
`ifdef ROB_RETIRE2_EN
    localparam int RMAX = 2;
`else
    localparam int RMAX = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.FU_COUNT(F)) bus ();
    reorder_buffer #(.ROB_ROW_COUNT(N), .FU_COUNT(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue of in-flight instructions.
    typedef struct packed {
        logic [5:0]  tag;
        logic [5:0]  p_rd;
        logic [5:0]  p_old;
        logic        sw;
        logic        done;
        logic [31:0] data;
    } m_ent_t;

    typedef struct packed {
        logic        v;
        logic [5:0]  prd;
        logic [31:0] data;
        logic        sw;
        logic        fv;
        logic [5:0]  fp;
    } m_ret_t;

    m_ent_t     q[$];
    m_ret_t     er[2];
    logic [5:0] tail_m = '0;
    bit         zero_all = 1'b0;

    task automatic idle();
        bus.alloc1_valid = 0; bus.alloc2_valid = 0;
        bus.alloc1_p_rd = 0; bus.alloc1_p_old_rd = 0; bus.alloc1_sw = 0;
        bus.alloc2_p_rd = 0; bus.alloc2_p_old_rd = 0; bus.alloc2_sw = 0;
        for (int p = 0; p < F; p++) begin
            bus.cmpl_valid[p] = 0;
            bus.cmpl_tag[p]   = 0;
            bus.cmpl_data[p]  = 0;
        end
    endtask

    task automatic alloc(input bit v1, input bit v2,
                         input logic [5:0] prd1, input logic [5:0] old1,
                         input bit sw1,
                         input logic [5:0] prd2, input logic [5:0] old2,
                         input bit sw2);
        bus.alloc1_valid = v1; bus.alloc2_valid = v2;
        bus.alloc1_p_rd = prd1; bus.alloc1_p_old_rd = old1; bus.alloc1_sw = sw1;
        bus.alloc2_p_rd = prd2; bus.alloc2_p_old_rd = old2; bus.alloc2_sw = sw2;
    endtask

    task automatic alloc_rand(input bit v1, input bit v2);
        logic [5:0] o1, o2;
        o1 = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
        o2 = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
        alloc(v1, v2, 6'($urandom), o1, 1'($urandom),
              6'($urandom), o2, 1'($urandom));
    endtask

    task automatic cmpl(input int p, input logic [5:0] tag,
                        input logic [31:0] d);
        bus.cmpl_valid[p] = 1;
        bus.cmpl_tag[p]   = tag;
        bus.cmpl_data[p]  = d;
    endtask

    task automatic model_step();
        int     n;
        bit     ready, claimed;
        m_ent_t e;
        er[0] = '0;
        er[1] = '0;
        if (rst) begin
            q.delete();
            tail_m   = '0;
            zero_all = 1'b1;
            return;
        end
        zero_all = 1'b0;
        ready    = q.size() <= N - 2;
        n = 0;
        while (n < RMAX && n < q.size() && q[n].done) begin
            er[n].v    = 1'b1;
            er[n].prd  = q[n].p_rd;
            er[n].data = q[n].data;
            er[n].sw   = q[n].sw;
            er[n].fv   = !q[n].sw && q[n].p_old != 0;
            er[n].fp   = q[n].p_old;
            n++;
        end
        for (int i = 0; i < F; i++) begin
            if (bus.cmpl_valid[i]) begin
                claimed = 1'b0;
                for (int j = 0; j < i; j++)
                    if (bus.cmpl_valid[j] && bus.cmpl_tag[j] == bus.cmpl_tag[i])
                        claimed = 1'b1;
                if (!claimed) begin
                    foreach (q[k]) begin
                        if (q[k].tag == bus.cmpl_tag[i]) begin
                            q[k].done = 1'b1;
                            q[k].data = bus.cmpl_data[i];
                        end
                    end
                end
            end
        end
        repeat (n) void'(q.pop_front());
        if (ready && bus.alloc1_valid) begin
            e = '{tag: tail_m, p_rd: bus.alloc1_p_rd,
                  p_old: bus.alloc1_p_old_rd, sw: bus.alloc1_sw,
                  done: 1'b0, data: 32'd0};
            q.push_back(e);
            tail_m = tail_m + 6'd1;
            if (bus.alloc2_valid) begin
                e = '{tag: tail_m, p_rd: bus.alloc2_p_rd,
                      p_old: bus.alloc2_p_old_rd, sw: bus.alloc2_sw,
                      done: 1'b0, data: 32'd0};
                q.push_back(e);
                tail_m = tail_m + 6'd1;
            end
        end
    endtask

    task automatic check_model();
        logic [5:0] t2;
        t2 = tail_m + 6'd1;
        chk("alloc_ready", bus.alloc_ready, q.size() <= N - 2);
        chk("alloc1_tag", bus.alloc1_tag, tail_m);
        chk("alloc2_tag", bus.alloc2_tag, t2);
        chk("rob_empty", bus.rob_empty, q.size() == 0);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("ret_valid%0d", s), bus.ret_valid[s], er[s].v);
            chk($sformatf("ret_free_valid%0d", s), bus.ret_free_valid[s], er[s].fv);
            if (er[s].v || zero_all) begin
                chk($sformatf("ret_p_rd%0d", s), bus.ret_p_rd[s], er[s].prd);
                chk($sformatf("ret_data%0d", s), bus.ret_data[s], er[s].data);
                chk($sformatf("ret_sw%0d", s), bus.ret_sw[s], er[s].sw);
                chk($sformatf("ret_free_preg%0d", s), bus.ret_free_preg[s], er[s].fp);
            end
        end
    endtask

    task automatic tick(input bit do_chk);
        if (do_chk) check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        bit rst; bit a1v; bit a2v;
        logic [5:0] a1prd; logic [5:0] a1old; bit a1sw;
        logic [5:0] a2prd; logic [5:0] a2old; bit a2sw;
        bit cv; logic [5:0] ctag; logic [31:0] cdata;
        bit e_ready; logic [5:0] e_tag; bit e_empty;
        bit e_rv0; logic [5:0] e_prd0; logic [31:0] e_rd0; bit e_sw0; bit e_fv0;
        bit e_rv1; logic [31:0] e_rd1;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [5:0] t2;
        idle();
        vt[0] = '{1, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,0,1, 0,0,0,0,0, 0,0};
        vt[1] = '{0, 1,1, 10,3,0, 11,0,0, 0,0,0,   1,2,0, 0,0,0,0,0, 0,0};
        vt[2] = '{0, 0,0, 0,0,0, 0,0,0, 1,1,'hB1,  1,2,0, 0,0,0,0,0, 0,0};
        vt[3] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,2,0, 0,0,0,0,0, 0,0};
        vt[4] = '{0, 0,0, 0,0,0, 0,0,0, 1,0,'hA0,  1,2,0, 0,0,0,0,0, 0,0};
`ifdef ROB_RETIRE2_EN
        vt[5] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,2,1, 1,10,'hA0,0,1, 1,'hB1};
        vt[6] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,2,1, 0,0,0,0,0, 0,0};
`else
        vt[5] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,2,0, 1,10,'hA0,0,1, 0,0};
        vt[6] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,2,1, 1,11,'hB1,0,0, 0,0};
`endif
        vt[7] = '{0, 1,0, 7,5,1, 0,0,0, 0,0,0,     1,3,0, 0,0,0,0,0, 0,0};
        vt[8] = '{0, 0,0, 0,0,0, 0,0,0, 1,2,5,     1,3,0, 0,0,0,0,0, 0,0};
        vt[9] = '{0, 0,0, 0,0,0, 0,0,0, 0,0,0,     1,3,1, 1,7,5,1,0, 0,0};

        for (int i = 0; i < 10; i++) begin
            idle();
            rst = vt[i].rst;
            alloc(vt[i].a1v, vt[i].a2v, vt[i].a1prd, vt[i].a1old, vt[i].a1sw,
                  vt[i].a2prd, vt[i].a2old, vt[i].a2sw);
            if (vt[i].cv) cmpl(0, vt[i].ctag, vt[i].cdata);
            @(posedge clk);
            #1;
            t2 = vt[i].e_tag + 6'd1;
            chk($sformatf("v%0d_ready", i), bus.alloc_ready, vt[i].e_ready);
            chk($sformatf("v%0d_tag1", i), bus.alloc1_tag, vt[i].e_tag);
            chk($sformatf("v%0d_tag2", i), bus.alloc2_tag, t2);
            chk($sformatf("v%0d_empty", i), bus.rob_empty, vt[i].e_empty);
            chk($sformatf("v%0d_rv0", i), bus.ret_valid[0], vt[i].e_rv0);
            chk($sformatf("v%0d_fv0", i), bus.ret_free_valid[0], vt[i].e_fv0);
            chk($sformatf("v%0d_rv1", i), bus.ret_valid[1], vt[i].e_rv1);
            if (vt[i].e_rv0) begin
                chk($sformatf("v%0d_prd0", i), bus.ret_p_rd[0], vt[i].e_prd0);
                chk($sformatf("v%0d_data0", i), bus.ret_data[0], vt[i].e_rd0);
                chk($sformatf("v%0d_sw0", i), bus.ret_sw[0], vt[i].e_sw0);
            end
            if (vt[i].e_rv1)
                chk($sformatf("v%0d_data1", i), bus.ret_data[1], vt[i].e_rd1);
        end

        idle();
        rst = 1;
        tick(0);
        rst = 0;

        for (int i = 0; i < 31; i++) begin
            alloc_rand(1, 1);
            tick(1);
        end
        idle();
        chk("fill62_ready", bus.alloc_ready, 1);
        alloc_rand(1, 0);
        tick(1);
        chk("full63_ready", bus.alloc_ready, 0);
        chk("full63_tag", bus.alloc1_tag, 63);
        alloc_rand(1, 1);
        tick(1);
        chk("full63_tag_hold", bus.alloc1_tag, 63);
        for (int c = 0; c < 21; c++) begin
            idle();
            for (int p = 0; p < F; p++)
                cmpl(p, 6'(3 * c + p), 32'h1000 + 32'(3 * c + p));
            tick(1);
        end
        idle();
        repeat (64) tick(1);
        chk("drain_empty", bus.rob_empty, 1);

        chk("wrap_tag1", bus.alloc1_tag, 63);
        chk("wrap_tag2", bus.alloc2_tag, 0);
        alloc(1, 1, 20, 21, 0, 22, 23, 0);
        tick(1);
        idle(); cmpl(0, 0, 32'hD000);
        tick(1);
        idle();
        tick(1);
        chk("wrap_hold", bus.ret_valid[0], 0);
        cmpl(0, 63, 32'hD063);
        tick(1);
        idle();
        tick(1);
        chk("wrap_first_data", bus.ret_data[0], 32'hD063);
        chk("wrap_first_prd", bus.ret_p_rd[0], 20);
        tick(1);
        tick(1);
        chk("wrap_empty", bus.rob_empty, 1);
        chk("wrap_tail", bus.alloc1_tag, 1);

        for (int i = 0; i < 5; i++) begin
            alloc_rand(1, 1);
            tick(1);
        end
        idle(); cmpl(0, 1, 32'h77);
        tick(1);
        rst = 1;
        alloc_rand(1, 1);
        cmpl(0, 2, 32'h22);
        cmpl(1, 3, 32'h33);
        tick(1);
        rst = 0;
        idle();
        chk("rst_empty", bus.rob_empty, 1);
        chk("rst_rv0", bus.ret_valid[0], 0);
        chk("rst_rv1", bus.ret_valid[1], 0);
        chk("rst_tag", bus.alloc1_tag, 0);
        chk("rst_ready", bus.alloc_ready, 1);
        tick(1);

        for (int c = 0; c < 3000; c++) begin
            int cp;
            logic [5:0] tg;
            idle();
            rst = ($urandom_range(0, 299) == 0);
            cp  = ((c / 250) % 2 == 1) ? 5 : 1;
            if ($urandom_range(0, 9) < 6)
                alloc_rand(1, 1'($urandom_range(0, 1)));
            for (int p = 0; p < F; p++) begin
                if ($urandom_range(0, cp) == 0) begin
                    if (q.size() > 0 && $urandom_range(0, 3) != 0)
                        tg = q[$urandom_range(0, q.size() - 1)].tag;
                    else
                        tg = 6'($urandom);
                    if (p > 0 && $urandom_range(0, 3) == 0)
                        tg = bus.cmpl_tag[0];
                    cmpl(p, tg, $urandom);
                end
            end
            tick(1);
        end
        rst = 0;
        idle();
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
